counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised bank of independent up/down counters sharing one prescaled count tick; the generalised successor to the single 8-bit counter. Each channel has its own load, direction, enable and mode (wrap, saturate, one-shot), a terminal-count pulse and a sticky done flag. It serves the game-timing layer (spawn timers, countdowns, animation frame counters) and sits between the control FSMs and the display logic.

## Interface
- `CHANNELS`, 4: number of independent counters (>=1)
- `WIDTH`, 8: counter width in bits
- `MAXCOUNT`, 255: top count value, must be <= 2**WIDTH-1
- `PRESCALE`, 1: tick divider; counters step once per PRESCALE clk cycles (>=1)

- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in CHANNELS: per-channel count enable
- `load` in CHANNELS: per-channel synchronous load strobe
- `countdown` in CHANNELS: 1 = count down, 0 = count up
- `mode` in CHANNELS x 2: per-channel `cnt_mode_e` (WRAP/SAT/ONESHOT)
- `load_value` in CHANNELS x WIDTH: value loaded on `load`
- `count_out` out CHANNELS x WIDTH: registered counts
- `tc` out CHANNELS: one-cycle terminal-count pulse
- `done` out CHANNELS: sticky one-shot completion flag
- `tick` out 1: registered prescaler tick (for observation and chaining)

## Operation
- Prescaler: counter `pre` 0..PRESCALE-1, increments every cycle and wraps; `tick` = 1 in the cycle `pre` == PRESCALE-1. PRESCALE=1 -> `tick` constantly 1 after reset.
- Terminal value: MAXCOUNT when counting up, 0 when counting down.
- Per-channel priority per edge: `load` > (`enable` && `tick` step) > hold.
- Load: count <= min(load_value, MAXCOUNT); `done` <= 0; `tc` <= 0.
- Step, count != terminal: count +/- 1; if the new value equals terminal: `tc` <= 1, and in ONESHOT `done` <= 1.
- Step, count == terminal:
  - WRAP: up -> 0, down -> MAXCOUNT; no `tc`.
  - SAT: hold; no `tc`.
  - ONESHOT: hold; `done` stays 1.
- ONESHOT with `done` = 1: no steps until `load`, even if direction changes.
- Values above MAXCOUNT reach the counter only via `load`, and `load` clamps them, so count is always <= MAXCOUNT.
- `mode` and `countdown` are sampled at each step; a change applies from the next step and needs no reload.
- Encoding value 2'b11 of `mode` behaves as WRAP.

## Timing
- Reset (`rst_n` low, asynchronous): `count_out` = 0, `tc` = 0, `done` = 0, `pre` = 0, `tick` = 0 (1 when PRESCALE=1, from the first edge after release).
- Load latency: `count_out` shows the loaded value after the edge where `load` = 1.
- Step latency: `count_out` updates on the edge where `enable` && `tick`.
- `tc`: registered and asserted for exactly the cycle in which `count_out` first shows terminal after a step. It never asserts on load, and never asserts while holding.
- `done` is registered on the same edge as its `tc` and holds until `load` or reset.
- Reset asserted mid-count clears everything immediately. After release, the prescaler phase restarts from 0.
- `load` and a step in the same cycle: `load` wins, the step is lost, and no `tc` is produced.

## Structure
- Package `counter_pkg`: `cnt_mode_e` enum (WRAP=2'b00, SAT=2'b01, ONESHOT=2'b10), plus a `terminal(dir)` helper function.
- Sub-module `counter_channel` (WIDTH, MAXCOUNT): one counter with its tc/done logic. It is generated CHANNELS times.
- The prescaler stays inline in `counter_bank`, with width $clog2(PRESCALE) (min 1).

## Test plan
- Reset then WRAP, up, PRESCALE=1, enable=1 from 250: counts 251..255, `tc` high only in the cycle showing 255, then 0, 1 with no `tc`.
- SAT down, load 3, PRESCALE=4: steps every 4th cycle 2,1,0; `tc` pulses once at 0; holds 0 for 20 further cycles with `tc` low.
- ONESHOT up, MAXCOUNT=10, load 8: 9, 10 with `tc`+`done` set; holds at 10 after toggling `countdown`; `load` 5 clears `done`, then counts 6.
- Load 300 with WIDTH=9, MAXCOUNT=255: `count_out` = 255 and `tc` = 0. Simultaneous `load`=7 and step: `count_out` = 7.
- Channels 0..3 in different modes and directions run concurrently: no cross-channel interference. Assert `rst_n` low mid-count: all outputs 0 at once, without waiting for a clk edge.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and helpers for the counter bank. Defines the
//               per-channel counting mode encoding and the terminal-value
//               helper used by every channel.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Per-channel counting mode. Encoding 2'b11 is not named and is treated
  // exactly like WRAP by the channels.
  typedef enum logic [1:0] {
    WRAP    = 2'b00,
    SAT     = 2'b01,
    ONESHOT = 2'b10
  } cnt_mode_e;

  localparam logic c_dir_up   = 1'b0;
  localparam logic c_dir_down = 1'b1;

  // Terminal value for a direction: the top count when counting up, zero
  // when counting down. The top count is passed in because it is a
  // per-instance parameter.
  function automatic logic [31:0] terminal(input logic dir, input logic [31:0] maxcount);
    return (dir == c_dir_down) ? 32'd0 : maxcount;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : counter_channel
// Description : One up/down counter with load, wrap/saturate/one-shot modes,
//               a one-cycle terminal-count pulse and a sticky done flag.
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               step_i       - advance by one this edge (enable && tick)
//               load_i       - synchronous load, wins over step_i
//               countdown_i  - 1 = count down, 0 = count up
//               mode_i       - cnt_mode_e encoding
//               load_value_i - value to load (clamped to MAXCOUNT)
//               count_o      - registered count
//               tc_o         - terminal-count pulse
//               done_o       - sticky one-shot completion flag
// Revision    : 1.0 - initial release
// ============================================================================
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAXCOUNT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic             countdown_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAXCOUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] w_term;
  logic             w_sat;
  logic             w_oneshot;

  assign w_term    = WIDTH'(terminal(countdown_i, 32'(MAXCOUNT)));
  assign w_sat     = (cnt_mode_e'(mode_i) == SAT);
  assign w_oneshot = (cnt_mode_e'(mode_i) == ONESHOT);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;     // tc is a single-cycle pulse, never held
    done_d  = done_q;
    if (load_i) begin
      count_d = (load_value_i > c_max) ? c_max : load_value_i;
      done_d  = 1'b0;
    end else if (step_i && !(w_oneshot && done_q)) begin
      // A finished one-shot ignores steps regardless of direction.
      if (count_q != w_term) begin
        count_d = countdown_i ? (count_q - 1'b1) : (count_q + 1'b1);
        if (count_d == w_term) begin
          tc_d = 1'b1;
          if (w_oneshot) begin
            done_d = 1'b1;
          end
        end
      end else if (!w_sat && !w_oneshot) begin
        // Wrap (and the unnamed encoding) roll over silently.
        count_d = countdown_i ? c_max : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;

endmodule
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : Bank of CHANNELS independent up/down counters stepping on a
//               shared prescaled tick.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               enable     - per-channel count enable
//               load       - per-channel synchronous load strobe
//               countdown  - per-channel direction (1 = down)
//               mode       - per-channel cnt_mode_e
//               load_value - per-channel load value
//               count_out  - per-channel registered count
//               tc         - per-channel terminal-count pulse
//               done       - per-channel sticky one-shot done flag
//               tick       - registered prescaler tick
// Revision    : 1.0 - initial release
// ============================================================================
module counter_bank
  import counter_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int MAXCOUNT = 255,
  parameter int PRESCALE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CHANNELS-1:0]             enable,
  input  logic [CHANNELS-1:0]             load,
  input  logic [CHANNELS-1:0]             countdown,
  input  logic [CHANNELS-1:0][1:0]        mode,
  input  logic [CHANNELS-1:0][WIDTH-1:0]  load_value,
  output logic [CHANNELS-1:0][WIDTH-1:0]  count_out,
  output logic [CHANNELS-1:0]             tc,
  output logic [CHANNELS-1:0]             done,
  output logic                            tick
);

  localparam int                 c_pre_w    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

  logic [c_pre_w-1:0] pre_q, pre_d;
  logic               tick_q, tick_d;

  // The tick register is loaded with the compare against the next prescaler
  // value, so tick is high exactly in the cycle where pre == PRESCALE-1.
  // With PRESCALE=1 the prescaler sits at 0 and tick is high from the first
  // edge after reset.
  always_comb begin
    pre_d  = (pre_q == c_pre_last) ? '0 : (pre_q + 1'b1);
    tick_d = (pre_d == c_pre_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
      counter_channel #(
        .WIDTH    (WIDTH),
        .MAXCOUNT (MAXCOUNT)
      ) u_channel (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_i       (enable[g] & tick_q),
        .load_i       (load[g]),
        .countdown_i  (countdown[g]),
        .mode_i       (mode[g]),
        .load_value_i (load_value[g]),
        .count_o      (count_out[g]),
        .tc_o         (tc[g]),
        .done_o       (done[g])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Scoreboard bench for counter_bank. Four instances cover the
//               prescale, one-shot, clamp and multi-channel cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A: 4 ch, 8 bit, max 255, prescale 1
  logic [3:0]      en_a, ld_a, dn_a, tc_a, done_a;
  logic [3:0][1:0] md_a;
  logic [3:0][7:0] lv_a, cnt_a;
  logic            tick_a;
  // B: prescale 4
  logic [0:0]      en_b, ld_b, dn_b, tc_b, done_b;
  logic [0:0][1:0] md_b;
  logic [0:0][7:0] lv_b, cnt_b;
  logic            tick_b;
  // C: max 10
  logic [0:0]      en_c, ld_c, dn_c, tc_c, done_c;
  logic [0:0][1:0] md_c;
  logic [0:0][7:0] lv_c, cnt_c;
  logic            tick_c;
  // D: 9 bit, max 255
  logic [0:0]      en_d, ld_d, dn_d, tc_d, done_d;
  logic [0:0][1:0] md_d;
  logic [0:0][8:0] lv_d, cnt_d;
  logic            tick_d;

  counter_bank #(.CHANNELS(4), .WIDTH(8), .MAXCOUNT(255), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .load(ld_a), .countdown(dn_a), .mode(md_a),
    .load_value(lv_a), .count_out(cnt_a), .tc(tc_a), .done(done_a), .tick(tick_a));
  counter_bank #(.CHANNELS(1), .WIDTH(8), .MAXCOUNT(255), .PRESCALE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .load(ld_b), .countdown(dn_b), .mode(md_b),
    .load_value(lv_b), .count_out(cnt_b), .tc(tc_b), .done(done_b), .tick(tick_b));
  counter_bank #(.CHANNELS(1), .WIDTH(8), .MAXCOUNT(10), .PRESCALE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .load(ld_c), .countdown(dn_c), .mode(md_c),
    .load_value(lv_c), .count_out(cnt_c), .tc(tc_c), .done(done_c), .tick(tick_c));
  counter_bank #(.CHANNELS(1), .WIDTH(9), .MAXCOUNT(255), .PRESCALE(1)) u_d (
    .clk(clk), .rst_n(rst_n), .enable(en_d), .load(ld_d), .countdown(dn_d), .mode(md_d),
    .load_value(lv_d), .count_out(cnt_d), .tc(tc_d), .done(done_d), .tick(tick_d));

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    int    cyc;
    int    id;
    int    ch;
    int    val;
    string name;
  } exp_t;
  exp_t sb[$];

  // Packed observation: bit 17 done, bit 16 tc, bits 15:0 count.
  function automatic int pack(int cnt, bit t, bit d);
    return (int'(d) << 17) | (int'(t) << 16) | cnt;
  endfunction

  function automatic int sample(int id, int ch);
    case (id)
      0:       return pack(int'(cnt_a[ch]), tc_a[ch], done_a[ch]);
      1:       return pack(int'(cnt_b[0]), tc_b[0], done_b[0]);
      2:       return pack(int'(cnt_c[0]), tc_c[0], done_c[0]);
      default: return pack(int'(cnt_d[0]), tc_d[0], done_d[0]);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h (bit17=done bit16=tc low=count)", nm, act, exp);
    end
  endtask

  // Expectation for the state visible after the next rising edge.
  task automatic expect_nxt(int id, int ch, int cnt, bit t, bit d, string nm);
    exp_t e;
    e.cyc  = cyc + 1;
    e.id   = id;
    e.ch   = ch;
    e.val  = pack(cnt, t, d);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every falling edge, retire all expectations due for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      chk($sformatf("%s[id%0d ch%0d cyc%0d]", e.name, e.id, e.ch, e.cyc), sample(e.id, e.ch), e.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int cyc_rel;
  int bcnt;
  bit bt;
  int nb;
  int ct[5][4] = '{'{100, 2, 3, 253}, '{101, 1, 2, 254}, '{102, 0, 1, 255},
                   '{103, 0, 0, 0},   '{104, 0, 0, 1}};
  bit tt[5][4] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 1, 0, 1}, '{0, 0, 1, 0}, '{0, 0, 0, 0}};
  bit dt[5][4] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 1, 0}, '{0, 0, 1, 0}};
  int wrap_seq[7] = '{251, 252, 253, 254, 255, 0, 1};

  initial begin
    en_a = '0; ld_a = '0; dn_a = '0; md_a = '0; lv_a = '0;
    en_b = '0; ld_b = '0; dn_b = '0; md_b = '0; lv_b = '0;
    en_c = '0; ld_c = '0; dn_c = '0; md_c = '0; lv_c = '0;
    en_d = '0; ld_d = '0; dn_d = '0; md_d = '0; lv_d = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_a", int'({done_a, tc_a, tick_a}), 0);
    chk("reset_cnt_a", int'(cnt_a), 0);

    // Release reset; load channel 0 of A on the same edge.
    @(negedge clk); #1;
    rst_n   = 1'b1;
    cyc_rel = cyc;
    ld_a[0] = 1'b1; lv_a[0] = 8'd250; md_a[0] = WRAP; dn_a[0] = 1'b0; en_a[0] = 1'b1;
    expect_nxt(0, 0, 250, 0, 0, "wrap_load");
    next();
    chk("tick_a_first", int'(tick_a), 1);
    chk("tick_b_first", int'(tick_b), 0);
    chk("tick_cd_first", int'({tick_c, tick_d}), 3);

    // WRAP up through the top: tc only in the cycle showing 255.
    ld_a[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      expect_nxt(0, 0, wrap_seq[i], (wrap_seq[i] == 255), 0, "wrap_up");
      next();
    end
    en_a[0] = 1'b0;

    // SAT down with PRESCALE=4: steps only on every 4th edge after release.
    ld_b = 1'b1; lv_b[0] = 8'd3; md_b[0] = SAT; dn_b = 1'b1; en_b = 1'b1;
    expect_nxt(1, 0, 3, 0, 0, "sat_load");
    next();
    ld_b = 1'b0;
    bcnt = 3;
    for (int i = 0; i < 36; i++) begin
      nb = cyc + 1 - cyc_rel;
      bt = 1'b0;
      if ((nb % 4) == 0 && bcnt > 0) begin
        bcnt--;
        bt = (bcnt == 0);
      end
      expect_nxt(1, 0, bcnt, bt, 0, "sat_down");
      next();
    end
    en_b = 1'b0;

    // ONESHOT up, max 10.
    ld_c = 1'b1; lv_c[0] = 8'd8; md_c[0] = ONESHOT; dn_c = 1'b0; en_c = 1'b1;
    expect_nxt(2, 0, 8, 0, 0, "os_load"); next();
    ld_c = 1'b0;
    expect_nxt(2, 0, 9, 0, 0, "os_step"); next();
    expect_nxt(2, 0, 10, 1, 1, "os_done"); next();
    expect_nxt(2, 0, 10, 0, 1, "os_hold"); next();
    dn_c = 1'b1;
    expect_nxt(2, 0, 10, 0, 1, "os_hold_dir"); next();
    expect_nxt(2, 0, 10, 0, 1, "os_hold_dir2"); next();
    ld_c = 1'b1; lv_c[0] = 8'd5; dn_c = 1'b0;
    expect_nxt(2, 0, 5, 0, 0, "os_reload"); next();
    ld_c = 1'b0;
    expect_nxt(2, 0, 6, 0, 0, "os_restart"); next();
    expect_nxt(2, 0, 7, 0, 0, "os_restart2"); next();
    en_c = 1'b0;

    // Clamp on load, wrap without tc, load beats step.
    ld_d = 1'b1; lv_d[0] = 9'd300; md_d[0] = WRAP; dn_d = 1'b0; en_d = 1'b1;
    expect_nxt(3, 0, 255, 0, 0, "clamp_load"); next();
    ld_d = 1'b0;
    expect_nxt(3, 0, 0, 0, 0, "wrap_top_no_tc"); next();
    ld_d = 1'b1; lv_d[0] = 9'd7;
    expect_nxt(3, 0, 7, 0, 0, "load_beats_step"); next();
    ld_d = 1'b0;
    expect_nxt(3, 0, 8, 0, 0, "after_load"); next();
    en_d = 1'b0;
    expect_nxt(3, 0, 8, 0, 0, "hold_disabled"); next();

    // Four channels concurrently in different modes and directions.
    md_a = {2'b11, ONESHOT, SAT, WRAP};
    dn_a = 4'b0110;
    lv_a = {8'd253, 8'd3, 8'd2, 8'd100};
    ld_a = 4'hF; en_a = 4'hF;
    for (int s = 0; s < 5; s++) begin
      for (int ch = 0; ch < 4; ch++) begin
        expect_nxt(0, ch, ct[s][ch], tt[s][ch], dt[s][ch], "multi");
      end
      next();
      ld_a = 4'h0;
    end

    // Asynchronous reset mid-count, between clock edges.
    en_b = 1'b1; en_c = 1'b1; en_d = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt_a", int'(cnt_a), 0);
    chk("async_flags_a", int'({done_a, tc_a, tick_a}), 0);
    chk("async_cnt_cd", int'({cnt_c, cnt_d}), 0);
    chk("async_b", int'({cnt_b, tc_b, done_b, tick_b}), 0);
    en_a = '0; en_b = '0; en_c = '0; en_d = '0;
    next();
    rst_n = 1'b1;
    next(); next();
    chk("prescale_restart_lo", int'(tick_b), 0);
    next();
    chk("prescale_restart_hi", int'(tick_b), 1);
    next();
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
